// File: rtl/impl_window_pkg.sv
// Shared encodings and parameter legality check for the implication window checker.
package impl_window_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StWait   = 2'd1;
  localparam state_t StWindow = 2'd2;

  typedef logic [1:0] verdict_t;
  localparam verdict_t VdNone  = 2'd0;
  localparam verdict_t VdPass  = 2'd1;
  localparam verdict_t VdFail  = 2'd2;
  localparam verdict_t VdAbort = 2'd3;

  function automatic bit dly_params_ok(int unsigned min_dly, int unsigned max_dly);
    return (min_dly >= 1) && (max_dly >= min_dly) && (max_dly <= 255);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (inc_in && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: rtl/impl_window_checker.sv
// Sequential implication checker: check must be followed by resp within MIN_DLY..MAX_DLY
// clocks; emits registered pass/fail/abort pulses and saturating statistics.
module impl_window_checker
  import impl_window_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             check_sig_in,
  input  logic             resp_sig_in,
  input  logic             disable_sig_in,
  output logic             pass_out,
  output logic             fail_out,
  output logic             abort_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] pass_cnt_out,
  output logic [CNT_W-1:0] fail_cnt_out,
  output logic [CNT_W-1:0] vacuous_cnt_out,
  output logic [CNT_W-1:0] overlap_cnt_out
);

  if (!dly_params_ok(MIN_DLY, MAX_DLY)) begin : g_bad_params
    $error("impl_window_checker: need 1 <= MIN_DLY <= MAX_DLY <= 255");
  end

  localparam int unsigned KW = $clog2(MAX_DLY + 1);
  localparam logic [KW-1:0] MinK = KW'(MIN_DLY);
  localparam logic [KW-1:0] MaxK = KW'(MAX_DLY);
  localparam logic [KW-1:0] OneK = KW'(1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  verdict_t      verdict_q, verdict_d;
  logic          vacuous_inc, overlap_inc;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    verdict_d   = VdNone;
    vacuous_inc = 1'b0;
    overlap_inc = 1'b0;
    if (state_q == StIdle) begin
      if (!disable_sig_in) begin
        if (check_sig_in) begin
          k_d     = OneK;
          state_d = (MIN_DLY == 1) ? StWindow : StWait;
        end else begin
          vacuous_inc = 1'b1;
        end
      end
    end else begin
      // An antecedent while busy is only tallied; it never starts a second attempt.
      overlap_inc = check_sig_in & ~disable_sig_in;
      if (disable_sig_in) begin
        verdict_d = VdAbort;
        state_d   = StIdle;
        k_d       = '0;
      end else if ((state_q == StWindow) && resp_sig_in) begin
        verdict_d = VdPass;
        state_d   = StIdle;
        k_d       = '0;
      end else if (k_q == MaxK) begin
        verdict_d = VdFail;
        state_d   = StIdle;
        k_d       = '0;
      end else begin
        k_d = k_q + OneK;
        if ((state_q == StWait) && ((k_q + OneK) == MinK)) begin
          state_d = StWindow;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      k_q       <= '0;
      verdict_q <= VdNone;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      verdict_q <= verdict_d;
    end
  end

  assign pass_out  = (verdict_q == VdPass);
  assign fail_out  = (verdict_q == VdFail);
  assign abort_out = (verdict_q == VdAbort);
  assign busy_out  = (state_q != StIdle);

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (verdict_d == VdPass),
    .cnt_out (pass_cnt_out)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (verdict_d == VdFail),
    .cnt_out (fail_cnt_out)
  );

  sat_counter #(.CNT_W(CNT_W)) u_vacuous_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (vacuous_inc),
    .cnt_out (vacuous_cnt_out)
  );

  sat_counter #(.CNT_W(CNT_W)) u_overlap_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (overlap_inc),
    .cnt_out (overlap_cnt_out)
  );

endmodule

// File: tb/tb_impl_window_checker.sv
// Bench for impl_window_checker: two configurations driven by shared stimulus, checked
// every cycle against an attempt-age model, plus literal expectations from the test plan.
module tb_impl_window_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, chk = 1'b0, rsp = 1'b0, dis = 1'b0;

  logic       pass0, fail0, abort0, busy0;
  logic [7:0] pc0, fc0, vc0, oc0;
  logic       pass1, fail1, abort1, busy1;
  logic [1:0] pc1, fc1, vc1, oc1;

  impl_window_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(8)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .check_sig_in(chk), .resp_sig_in(rsp), .disable_sig_in(dis),
    .pass_out(pass0), .fail_out(fail0), .abort_out(abort0), .busy_out(busy0),
    .pass_cnt_out(pc0), .fail_cnt_out(fc0), .vacuous_cnt_out(vc0), .overlap_cnt_out(oc0)
  );

  impl_window_checker #(.MIN_DLY(2), .MAX_DLY(4), .CNT_W(2)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .check_sig_in(chk), .resp_sig_in(rsp), .disable_sig_in(dis),
    .pass_out(pass1), .fail_out(fail1), .abort_out(abort1), .busy_out(busy1),
    .pass_cnt_out(pc1), .fail_cnt_out(fc1), .vacuous_cnt_out(vc1), .overlap_cnt_out(oc1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit active;
    int age;
    bit pass, fail, abort;
    int pc, fc, vc, oc;
  } model_t;

  model_t m[2];
  int min_d[2] = '{1, 2};
  int cmax[2]  = '{255, 3};
  localparam int MaxD = 4;

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Attempt tracked as "active + age in clocks since the antecedent".
  function automatic model_t step_model(model_t s, int mn, int lim, bit r, bit c, bit rs, bit d);
    model_t n;
    n = s;
    n.pass = 0; n.fail = 0; n.abort = 0;
    if (r) begin
      n = '{default: 0};
    end else if (!s.active) begin
      if (!d) begin
        if (c) begin
          n.active = 1;
          n.age = 1;
        end else begin
          n.vc = sat(s.vc + 1, lim);
        end
      end
    end else begin
      if (c && !d) n.oc = sat(s.oc + 1, lim);
      if (d) begin
        n.abort = 1; n.active = 0;
      end else if (s.age >= mn && rs) begin
        n.pass = 1; n.active = 0; n.pc = sat(s.pc + 1, lim);
      end else if (s.age == MaxD) begin
        n.fail = 1; n.active = 0; n.fc = sat(s.fc + 1, lim);
      end else begin
        n.age = s.age + 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_one(input int i, input logic p, input logic f, input logic a,
                             input logic b, input logic [31:0] pc, input logic [31:0] fc,
                             input logic [31:0] vc, input logic [31:0] oc);
    check($sformatf("u%0d.pass", i), {31'b0, p}, {31'b0, m[i].pass});
    check($sformatf("u%0d.fail", i), {31'b0, f}, {31'b0, m[i].fail});
    check($sformatf("u%0d.abort", i), {31'b0, a}, {31'b0, m[i].abort});
    check($sformatf("u%0d.busy", i), {31'b0, b}, {31'b0, m[i].active});
    check($sformatf("u%0d.pass_cnt", i), pc, m[i].pc);
    check($sformatf("u%0d.fail_cnt", i), fc, m[i].fc);
    check($sformatf("u%0d.vacuous_cnt", i), vc, m[i].vc);
    check($sformatf("u%0d.overlap_cnt", i), oc, m[i].oc);
  endtask

  // Drive one edge's inputs, advance the model at the edge, compare at the next negedge.
  task automatic cyc(input bit r, input bit c, input bit rs, input bit d);
    rst = r; chk = c; rsp = rs; dis = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = step_model(m[i], min_d[i], cmax[i], r, c, rs, d);
    @(negedge clk);
    compare_one(0, pass0, fail0, abort0, busy0, 32'(pc0), 32'(fc0), 32'(vc0), 32'(oc0));
    compare_one(1, pass1, fail1, abort1, busy1, 32'(pc1), 32'(fc1), 32'(vc1), 32'(oc1));
  endtask

  initial begin
    m[0] = '{default: 0};
    m[1] = '{default: 0};

    // Reset state and basic pass.
    cyc(1, 0, 0, 0);
    check("lit_reset_busy", 32'(busy0), 0);
    check("lit_reset_pass_cnt", 32'(pc0), 0);
    cyc(0, 1, 0, 0);
    check("lit_basic_busy_c1", 32'(busy0), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("lit_basic_pass", 32'(pass0), 1);
    check("lit_basic_busy_done", 32'(busy0), 0);
    check("lit_basic_pass_cnt", 32'(pc0), 1);
    cyc(0, 0, 0, 0);
    check("lit_basic_pass_one_cycle", 32'(pass0), 0);

    // Window expiry, then a late resp that must not pass.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    check("lit_expiry_no_early_fail", 32'(fail0), 0);
    cyc(0, 0, 0, 0);
    check("lit_expiry_fail", 32'(fail0), 1);
    check("lit_expiry_fail_cnt", 32'(fc0), 1);
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("lit_late_resp_no_pass", 32'(pass0), 0);
    check("lit_late_resp_pass_cnt", 32'(pc0), 0);
    check("lit_late_resp_fail_cnt", 32'(fc0), 2);

    // Disable beats a simultaneous resp.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    check("lit_dis_abort", 32'(abort0), 1);
    check("lit_dis_no_pass", 32'(pass0), 0);
    check("lit_dis_pass_cnt", 32'(pc0), 0);
    check("lit_dis_fail_cnt", 32'(fc0), 0);

    // Overlap and restart with check held high.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    check("lit_ovl_pass_e1", 32'(pass0), 1);
    check("lit_ovl_cnt_e1", 32'(oc0), 1);
    cyc(0, 1, 0, 0);
    check("lit_ovl_restart_busy", 32'(busy0), 1);
    cyc(0, 1, 1, 0);
    check("lit_ovl_pass_cnt", 32'(pc0), 2);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);

    // MIN_DLY=2: resp at edge 1 is too early, the attempt then expires.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    check("lit_min2_u0_pass", 32'(pass0), 1);
    check("lit_min2_u1_no_pass", 32'(pass1), 0);
    check("lit_min2_u1_busy", 32'(busy1), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("lit_min2_no_early_fail", 32'(fail1), 0);
    cyc(0, 0, 0, 0);
    check("lit_min2_fail", 32'(fail1), 1);
    check("lit_min2_fail_cnt", 32'(fc1), 1);
    check("lit_min2_pass_cnt", 32'(pc1), 0);

    // Saturation of the 2-bit vacuous counter.
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    check("lit_sat_vc1", 32'(vc1), 3);
    check("lit_sat_vc0", 32'(vc0), 5);
    cyc(0, 0, 0, 0);
    check("lit_sat_vc1_hold", 32'(vc1), 3);

    // Reset mid-attempt.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("lit_midrst_busy", 32'(busy0), 0);
    check("lit_midrst_vc", 32'(vc0), 0);
    check("lit_midrst_no_fail", 32'(fail0), 0);
    check("lit_midrst_no_abort", 32'(abort0), 0);
    cyc(0, 1, 0, 0);
    check("lit_midrst_restart", 32'(busy0), 1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) < 3, $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/impl_window_checker.md
Name: impl_window_checker

Overview:
- Sequential implication checker: antecedent check_sig_in sampled high starts an attempt; consequent resp_sig_in must be sampled high within MIN_DLY..MAX_DLY clocks; disable_sig_in aborts.
- Consumes the same check/disable/clock triplet as the property-success stage and sits directly downstream of it, turning per-cycle property outcomes into registered pass/fail pulses and saturating statistics for the MiscSystemFuncs result collector.

Parameters:
MIN_DLY, 1, earliest consequent delay in clocks after the antecedent edge; must be >= 1.
MAX_DLY, 4, latest consequent delay; must be >= MIN_DLY and <= 255; violation is an elaboration error.
CNT_W, 8, width of each statistics counter.

Ports:
clk_in  input  1  sole clock; all sampling on posedge.
rst_in  input  1  synchronous, active-high reset.
check_sig_in  input  1  antecedent.
resp_sig_in  input  1  consequent.
disable_sig_in  input  1  disable iff; aborts an in-flight attempt.
pass_out  output  1  one-cycle pulse: attempt passed.
fail_out  output  1  one-cycle pulse: window expired without consequent.
abort_out  output  1  one-cycle pulse: attempt killed by disable.
busy_out  output  1  attempt in flight (state != IDLE).
pass_cnt_out  output  CNT_W  saturating pass count.
fail_cnt_out  output  CNT_W  saturating fail count.
vacuous_cnt_out  output  CNT_W  saturating count of IDLE edges with check low and disable low.
overlap_cnt_out  output  CNT_W  saturating count of antecedents sampled while busy (ignored).

Behaviour:
- Reset (rst_in high at an edge): state IDLE, delay counter 0, all outputs 0, all counters 0. Reset mid-attempt discards it with no pulse. Reset beats every other input.
- States: IDLE, WAIT (k < MIN_DLY), WINDOW (MIN_DLY <= k <= MAX_DLY). k is the edge count since the antecedent edge (k=0).
- IDLE:
  - disable high -> stay; nothing counted.
  - check high -> start: k := 1 at the next edge; go to WAIT, or to WINDOW if MIN_DLY == 1.
  - check low -> vacuous_cnt++.
- At each edge while busy, priority order:
  1. disable high -> abort, IDLE.
  2. In WINDOW, resp high -> pass, IDLE.
  3. k == MAX_DLY, resp low -> fail, IDLE.
  4. Otherwise k++; WAIT -> WINDOW when k+1 == MIN_DLY.
  - resp high during WAIT is ignored.
- Pulses and counters are registered and visible in the cycle after the deciding edge. pass/fail/abort are mutually exclusive; each is high for exactly one cycle.
- busy_out is registered from the state: high in the cycle after the starting edge, low in the cycle after the deciding edge.
- Overlap: check high at any edge while busy (including the deciding edge) -> overlap_cnt++. No new attempt starts on that edge, so the earliest restart is the edge after return to IDLE. If disable is also high, overlap is not counted.
- Counters saturate at 2^CNT_W-1; no wrap.
- Delay counter width: $clog2(MAX_DLY+1).
- Worst-case latency antecedent->verdict pulse: MAX_DLY+1 cycles.

Decomposition:
- Package impl_window_pkg:
  - state enum (IDLE, WAIT, WINDOW)
  - verdict enum (NONE, PASS, FAIL, ABORT)
  - parameter legality check function
- One sub-module: sat_counter (CNT_W, inc, synchronous rst_in), instantiated four times.

Test Plan:
(Defaults MIN_DLY=1, MAX_DLY=4.)
- Basic pass: check=1 at edge 0, resp=1 at edge 2 -> pass_out high for the cycle after edge 2; busy_out high in cycles 1-2; pass_cnt=1.
- Window expiry: check=1 at edge 0, resp held 0 -> fail_out pulse after edge 4; fail_cnt=1. Repeat with resp=1 at edge 5 -> still fail, no pass.
- Disable priority: start at edge 0; at edge 3 drive disable=1 and resp=1 together -> abort_out only; pass_cnt and fail_cnt unchanged.
- Overlap/restart: check held 1 for 6 edges, resp=1 at edge 1 -> pass after edge 1, overlap_cnt=1 (edge 1), new attempt starts at edge 2, pass_cnt reaches 2 when resp is again high at edge 3. With MIN_DLY=2, resp=1 at edge 1 only -> fail at edge 4.
- Saturation: CNT_W=2, 5 vacuous idle edges -> vacuous_cnt_out=3, holds at 3.
- Reset mid-attempt: start at edge 0, rst_in=1 at edge 2 -> no pulse, busy_out=0 and all counters 0 after edge 2; check=1 at edge 3 starts a fresh attempt.
